// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer.
// No logic of its own: state encoding, counter sizing, default parameters.
// Nothing here carries flow control.
package reset_seq_pkg;

  localparam int DEF_N_DOM       = 4;
  localparam int DEF_STEP_CYCLES = 16;
  localparam int DEF_HOLD_CYCLES = 8;

  // 3-bit encoding; SOFT_DRAIN is only reachable in the reverse-assert build.
  typedef enum logic [2:0] {
    S_ASSERT     = 3'd0,
    S_WAIT_LOCK  = 3'd1,
    S_RELEASE    = 3'd2,
    S_RUN        = 3'd3,
    S_SOFT       = 3'd4,
    S_SOFT_DRAIN = 3'd5
  } seq_state_e;

  // Wide enough for the longest run of any single state; the counter
  // clears on every state change so it never has to wrap.
  function automatic int cnt_width(input int n_dom, input int step, input int hold);
    return $clog2(n_dom * step + hold + 1);
  endfunction

endpackage

// File: rtl/reset_seq_sync2.sv
// Two-flop synchronizer for a single bit, optional asynchronous clear.
// Latency: d appears on q two clk edges later; clear forces q low at once.
// No backpressure: free-running sampler.
module sync2_bit #(
  parameter bit USE_CLEAR = 1'b1
) (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);

  logic meta;

  generate
    if (USE_CLEAR) begin : g_clr
      // Shift d through two flops; clear drops both flops immediately.
      always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
          meta <= 1'b0;
          q    <= 1'b0;
        end else begin
          meta <= d;
          q    <= meta;
        end
      end
    end else begin : g_plain
      logic unused_clr;
      assign unused_clr = clr_n;

      // Plain two-stage sampling with no clear.
      always_ff @(posedge clk) begin
        meta <= d;
        q    <= meta;
      end
    end
  endgenerate

endmodule

// File: rtl/reset_sequencer.sv
// Releases N_DOM active-low reset domains in order after board reset and PLL lock; soft-reset handshake.
// Latency: domain k releases (k+1)*STEP_CYCLES edges after RELEASE entry; all outputs registered.
// No backpressure; soft_req is a level held until soft_ack. Macro RESET_SEQ_REVERSE_ASSERT_EN: staged soft assert.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_DOM       = DEF_N_DOM,
  parameter int STEP_CYCLES = DEF_STEP_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic             clk,
  input  logic             reset_in_,
  input  logic             pll_locked_in,
  input  logic             soft_req,
  output logic             soft_ack,
  output logic [N_DOM-1:0] rst_out_,
  output logic             seq_done
);

  localparam int CW = cnt_width(N_DOM, STEP_CYCLES, HOLD_CYCLES);

  logic rst_n;
  logic lock;

  // Board reset: asserts asynchronously, releases two edges after it rises.
  sync2_bit #(.USE_CLEAR(1'b1)) u_rst_sync (
    .clk   (clk),
    .clr_n (reset_in_),
    .d     (1'b1),
    .q     (rst_n)
  );

  // PLL lock comes from another clock domain; sample it without a clear.
  sync2_bit #(.USE_CLEAR(1'b0)) u_lock_sync (
    .clk   (clk),
    .clr_n (1'b1),
    .d     (pll_locked_in),
    .q     (lock)
  );

  seq_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_DOM-1:0] rst_q, rst_d;
  logic             done_q, done_d;
  logic             ack_q, ack_d;
  logic             pend_q, pend_d;
  logic             lock_lost;
  int               cnt_nxt;
  logic [N_DOM-1:0] rel_hit;

  // Cycle number the counter reaches at the coming edge.
  assign cnt_nxt = int'(cnt_q) + 1;

  // Losing lock only matters once domains may already be running.
  assign lock_lost = !lock && (state_q inside {S_RELEASE, S_RUN, S_SOFT, S_SOFT_DRAIN});

  for (genvar k = 0; k < N_DOM; k++) begin : g_rel
    assign rel_hit[k] = (cnt_nxt == (k + 1) * STEP_CYCLES);
  end

`ifdef RESET_SEQ_REVERSE_ASSERT_EN
  logic [N_DOM-1:0] drain_hit;
  // Domain N_DOM-1 drops on entry; domain k follows (N_DOM-1-k)*STEP_CYCLES later.
  for (genvar k = 0; k < N_DOM; k++) begin : g_drain
    assign drain_hit[k] = (cnt_nxt == (N_DOM - 1 - k) * STEP_CYCLES);
  end
`endif

  // State, counter and every output are flops cleared by the synchronized reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ASSERT;
      cnt_q   <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state and next-output logic for the sequencing FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    rst_d   = rst_q;
    done_d  = done_q;
    ack_d   = ack_q;
    pend_d  = pend_q;

    // Four-phase return: ack falls once the requester drops its level.
    if (!soft_req) ack_d = 1'b0;

    if (lock_lost) begin
      // Everything goes back down together; a pending ack is kept.
      state_d = S_ASSERT;
      cnt_d   = '0;
      rst_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_ASSERT: begin
          rst_d  = '0;
          done_d = 1'b0;
          if (cnt_nxt == HOLD_CYCLES) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        S_WAIT_LOCK: begin
          cnt_d = '0;
          if (lock) state_d = S_RELEASE;
        end
        S_RELEASE: begin
          rst_d = rst_q | rel_hit;
          if (rel_hit[N_DOM-1]) begin
            state_d = S_RUN;
            cnt_d   = '0;
            done_d  = 1'b1;
            if (pend_q) begin
              ack_d  = 1'b1;
              pend_d = 1'b0;
            end
          end
        end
        S_RUN: begin
          cnt_d = '0;
          if (soft_req && !ack_q) begin
            // Pending is latched at acceptance so a lock loss anywhere
            // in the soft cycle cannot swallow the acknowledge.
            pend_d = 1'b1;
            done_d = 1'b0;
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
            rst_d[N_DOM-1] = 1'b0;
            state_d = (N_DOM > 1) ? S_SOFT_DRAIN : S_SOFT;
`else
            rst_d   = '0;
            state_d = S_SOFT;
`endif
          end
        end
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
        S_SOFT_DRAIN: begin
          rst_d = rst_q & ~drain_hit;
          if (drain_hit[0]) begin
            state_d = S_SOFT;
            cnt_d   = '0;
          end
        end
`endif
        S_SOFT: begin
          if (cnt_nxt == HOLD_CYCLES) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = S_ASSERT;
          cnt_d   = '0;
          rst_d   = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  assign rst_out_ = rst_q;
  assign seq_done = done_q;
  assign soft_ack = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized bench: a timeline model predicts every output change (edge number and value);
// a negedge monitor pops and compares each observed change against the queue.
// Scenarios: late lock, soft resets, lock glitches, lock loss in SOFT, reset pulse mid-release.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int N   = DEF_N_DOM;
  localparam int S   = DEF_STEP_CYCLES;
  localparam int H   = DEF_HOLD_CYCLES;
  localparam int BIG = 32'h7fff_ffff;
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
  localparam int SOFT_SPAN = (N - 1) * S + H;
`else
  localparam int SOFT_SPAN = H;
`endif

  logic         clk = 1'b0;
  logic         reset_in_ = 1'b0;
  logic         pll_locked_in = 1'b0;
  logic         soft_req = 1'b0;
  logic         soft_ack;
  logic [N-1:0] rst_out_;
  logic         seq_done;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int           edge_no;
    logic [N+1:0] val;    // {soft_ack, seq_done, rst_out_}
  } ev_t;

  ev_t          exp_q[$];
  logic [N+1:0] cur = '0;
  logic [N+1:0] prev_obs = '0;

  reset_sequencer #(.N_DOM(N), .STEP_CYCLES(S), .HOLD_CYCLES(H)) dut (
    .clk           (clk),
    .reset_in_     (reset_in_),
    .pll_locked_in (pll_locked_in),
    .soft_req      (soft_req),
    .soft_ack      (soft_ack),
    .rst_out_      (rst_out_),
    .seq_done      (seq_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any change of the outputs must match the next predicted event.
  always @(negedge clk) begin
    logic [N+1:0] obs;
    ev_t          ev;
    obs = {soft_ack, seq_done, rst_out_};
    if (obs !== prev_obs) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_change edge=%0d got=%b required no change", cyc, obs);
      end else begin
        ev = exp_q.pop_front();
        if (ev.edge_no == cyc && ev.val === obs) n_pass++;
        else $display("FAIL out_change got edge=%0d val=%b required edge=%0d val=%b",
                      cyc, obs, ev.edge_no, ev.val);
      end
      prev_obs = obs;
    end
  end

  function automatic int rnd(input int lo, input int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  function automatic logic [N-1:0] low_ones(input int k);
    logic [N-1:0] v = '0;
    for (int i = 0; i < k; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Record a predicted output value at an edge, only if it differs.
  task automatic push_ev(input int e, input logic ack, input logic done, input logic [N-1:0] r);
    logic [N+1:0] v;
    ev_t          t;
    v = {ack, done, r};
    if (v !== cur) begin
      t.edge_no = e;
      t.val     = v;
      exp_q.push_back(t);
      cur = v;
    end
  endtask

  // Release phase entered at edge rel: domain k free at rel+(k+1)*S.
  task automatic model_seq(input int rel, input bit give_ack, input int cut, output int t_run);
    for (int k = 0; k < N; k++) begin
      int e;
      e = rel + (k + 1) * S;
      if (e < cut) begin
        if (k == N - 1) push_ev(e, cur[N+1] | give_ack, 1'b1, low_ones(N));
        else            push_ev(e, cur[N+1], 1'b0, low_ones(k + 1));
      end
    end
    t_run = rel + N * S;
  endtask

  // Soft reset accepted at edge a; returns the edge the next release phase starts.
  task automatic model_soft(input int a, input int cut, output int rel);
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
    for (int j = 0; j < N; j++)
      if (a + j * S < cut) push_ev(a + j * S, cur[N+1], 1'b0, low_ones(N - 1 - j));
`else
    if (a < cut) push_ev(a, cur[N+1], 1'b0, '0);
`endif
    rel = a + SOFT_SPAN + 1;
  endtask

  // Lock loss seen at edge l (lock already back): assert all, hold, wait, release.
  task automatic model_lock_loss(input int l, output int rel);
    push_ev(l, cur[N+1], 1'b0, '0);
    rel = l + H + 1;
  endtask

  // Inputs change 1 time unit after edge e.
  task automatic wait_to(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle lock drop whose synchronized effect lands at edge l.
  task automatic lock_glitch(input int l);
    wait_to(l - 3);
    pll_locked_in = 1'b0;
    wait_to(l - 2);
    pll_locked_in = 1'b1;
  endtask

  // Hold the request a while after ack, then drop it; ack falls next edge.
  task automatic drop_req(input int t_ack);
    wait_to(t_ack + rnd(1, 8));
    push_ev(cyc + 1, 1'b0, cur[N], cur[N-1:0]);
    soft_req = 1'b0;
    wait_to(cyc + rnd(2, 5));
  endtask

  initial begin
    int r, d, rel, rel2, trun, trun2, a, l1, l2, e, p, sr, dummy;

    // Reset state while reset_in_ is low.
    wait_to(3);
    n_chk++;
    if ({soft_ack, seq_done, rst_out_} === '0) n_pass++;
    else $display("FAIL reset_state got=%b required=0", {soft_ack, seq_done, rst_out_});

    // Power-up with late lock: release waits for both hold and lock.
    r = 4;
    d = r + rnd(2, 40);
    rel = (d + 3 > r + H + 3) ? d + 3 : r + H + 3;
    model_seq(rel, 1'b0, BIG, trun);
    wait_to(r);
    reset_in_ = 1'b1;
    wait_to(d);
    pll_locked_in = 1'b1;
    wait_to(trun + rnd(1, 5));

    for (int it = 0; it < 3; it++) begin
      // Plain soft reset, request held past ack.
      a = cyc + 1;
      model_soft(a, BIG, rel);
      model_seq(rel, 1'b1, BIG, trun);
      soft_req = 1'b1;
      drop_req(trun);

      // Lock glitch in RUN, second glitch mid-release, then a request raised
      // during release that must wait for RUN.
      l1 = cyc + rnd(3, 8);
      model_lock_loss(l1, rel);
      l2 = rel + rnd(1, N * S - 1);
      model_seq(rel, 1'b0, l2, dummy);
      model_lock_loss(l2, rel);
      model_seq(rel, 1'b0, BIG, trun);
      sr = rel + rnd(0, N * S - 2);
      model_soft(trun + 1, BIG, rel2);
      model_seq(rel2, 1'b1, BIG, trun2);
      lock_glitch(l1);
      lock_glitch(l2);
      wait_to(sr);
      soft_req = 1'b1;
      drop_req(trun2);

      // Lock loss during the soft hold: the acknowledge still arrives.
      a = cyc + 1;
      e = a + rnd(3, SOFT_SPAN - 1);
      model_soft(a, e, dummy);
      model_lock_loss(e, rel);
      model_seq(rel, 1'b1, BIG, trun);
      soft_req = 1'b1;
      lock_glitch(e);
      drop_req(trun);
    end

    // Board reset pulsed after domain 1 is out: async clear, pending lost,
    // full power-up, then the still-high request is serviced afresh.
    a = cyc + 1;
    model_soft(a, BIG, rel);
    p = rel + 2 * S + rnd(1, S - 1);
    model_seq(rel, 1'b1, p + 1, dummy);
    push_ev(p, 1'b0, 1'b0, '0);
    r = p + rnd(1, 3);
    model_seq(r + H + 3, 1'b0, BIG, trun);
    model_soft(trun + 1, BIG, rel2);
    model_seq(rel2, 1'b1, BIG, trun2);
    soft_req = 1'b1;
    wait_to(p);
    reset_in_ = 1'b0;
    wait_to(r);
    reset_in_ = 1'b1;
    drop_req(trun2);

    wait_to(cyc + 20);
    n_chk++;
    if ({soft_ack, seq_done, rst_out_} === cur) n_pass++;
    else $display("FAIL final_state got=%b required=%b", {soft_ack, seq_done, rst_out_}, cur);
    while (exp_q.size() > 0) begin
      ev_t ev;
      ev = exp_q.pop_front();
      n_chk++;
      $display("FAIL missing_change got none required edge=%0d val=%b", ev.edge_no, ev.val);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
